// File: rtl/idx_alloc.sv
// rtl/idx_alloc.sv - lowest-free index allocator with encoded allocate/free handshakes
// Offers the lowest free entry; legal frees return entries, illegal frees pulse o_err.
module idx_alloc #(
  parameter  int N  = 16,
  localparam int W  = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_alloc_acc,
  output logic          o_alloc_vld,
  output logic [W-1:0]  o_alloc_idx,
  input  logic          i_free_vld,
  input  logic [W-1:0]  i_free_idx,
  output logic [N-1:0]  o_busy,
  output logic [CW-1:0] o_free_cnt,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_err
);

  logic [N-1:0]  busy;
  logic [N-1:0]  busy_nxt;
  logic [CW-1:0] free_cnt;
  logic          err;
  logic [W-1:0]  low_idx;
  logic          alloc_fire;
  logic          free_hit;
  logic          free_ok;

  // Descending scan so the lowest free entry wins; 0 when nothing is free.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) low_idx = W'(i);
    end
  end

  // Matching against real entries only also rejects out-of-range indices.
  always_comb begin
    free_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_free_idx == W'(i) && busy[i]) free_hit = 1'b1;
    end
  end

  assign alloc_fire = i_alloc_acc & o_alloc_vld;
  assign free_ok    = i_free_vld & free_hit;

  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < N; i++) begin
      if (alloc_fire && low_idx == W'(i))  busy_nxt[i] = 1'b1;
      if (free_ok && i_free_idx == W'(i))  busy_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      free_cnt <= CW'(N);
      err      <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (alloc_fire && !free_ok)
        free_cnt <= free_cnt - CW'(1);
      else if (free_ok && !alloc_fire)
        free_cnt <= free_cnt + CW'(1);
      err <= i_free_vld & ~free_hit;
    end
  end

  assign o_alloc_vld = ~rst & (free_cnt != '0);
  assign o_alloc_idx = o_alloc_vld ? low_idx : '0;
  assign o_busy      = busy;
  assign o_free_cnt  = free_cnt;
  assign o_full      = (free_cnt == '0);
  assign o_empty     = (free_cnt == CW'(N));
  assign o_err       = err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($countones(busy) + int'(free_cnt) == N);
      if (o_alloc_vld) assert (int'(o_alloc_idx) < N);
    end
  end

endmodule
